// File: rtl/cpu_pkg.sv
// Shared fetch-unit types and defaults.
// Widths, reset vector, NOP encoding and the fetch FSM states.
package cpu_pkg;

   localparam int          CPU_PC_W    = 9;
   localparam int          CPU_INSTR_W = 12;
   localparam int          CPU_TIMEOUT = 15;
   localparam logic [8:0]  CPU_RST_VEC = 9'h1FF;
   localparam logic [11:0] CPU_NOP     = 12'h000;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_EXEC  = 2'd3
   } fetch_state_t;

   function automatic logic [7:0] sat_inc8(
      input logic [7:0] v
   );
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus.
// master = fetch unit, slave = memory.
interface instr_fetch_if #(
   parameter int PC_W    = 9,
   parameter int INSTR_W = 12
);

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_timeout.sv
// Fetch wait-cycle counter with timeout pulse
// and saturating 8-bit error count.
module fetch_timeout
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = CPU_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arm,
   input  logic       run,
   input  logic       rvalid,
   output logic       expired,
   output logic       fetch_err,
   output logic [7:0] err_cnt
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   // A response in the last wait cycle beats the timeout.
   assign expired = run && !rvalid &&
                    (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         fetch_err <= 1'b0;
         err_cnt   <= 8'd0;
      end else begin
         fetch_err <= expired;
         if (expired)
            err_cnt <= sat_inc8(err_cnt);
         if (arm)
            cnt <= '0;
         else if (run && !rvalid)
            cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit:
// RESET -> REQ -> WAIT -> EXEC, with timeout retry.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int              PC_W    = CPU_PC_W,
   parameter int              INSTR_W = CPU_INSTR_W,
   parameter logic [PC_W-1:0] RST_VEC = PC_W'(CPU_RST_VEC),
   parameter int              TIMEOUT = CPU_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PC_W-1:0]    pc_next,
   input  logic               stall,
   instr_fetch_if.master      imem,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic               fetch_err,
   output logic [7:0]         err_cnt
);

   localparam logic [INSTR_W-1:0] NOP =
      INSTR_W'(CPU_NOP);

   fetch_state_t       state;
   fetch_state_t       state_nx;
   logic [PC_W-1:0]    pc_nx;
   logic [INSTR_W-1:0] instr_nx;
   logic               expired;

   fetch_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .arm       (state == ST_REQ),
      .run       (state == ST_WAIT),
      .rvalid    (imem.imem_rvalid),
      .expired   (expired),
      .fetch_err (fetch_err),
      .err_cnt   (err_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RESET;
         pc    <= RST_VEC;
         instr <= NOP;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         instr <= instr_nx;
      end
   end

   // rvalid only matters in WAIT; anything else is stale.
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      instr_nx = instr;
      unique case (state)
         ST_RESET: state_nx = ST_REQ;
         ST_REQ:   state_nx = ST_WAIT;
         ST_WAIT: begin
            if (imem.imem_rvalid) begin
               instr_nx = imem.imem_rdata;
               state_nx = ST_EXEC;
            end else if (expired) begin
               state_nx = ST_REQ;
            end
         end
         ST_EXEC: begin
            if (!stall) begin
               pc_nx    = pc_next;
               state_nx = ST_REQ;
            end
         end
         default: state_nx = ST_RESET;
      endcase
   end

   assign imem.imem_req  = (state == ST_REQ);
   assign imem.imem_addr = pc;
   assign instr_valid    = (state == ST_EXEC);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: expected
// (pc, instr) pairs are queued as responses are driven.
module tb_instr_fetch;

   localparam int PW = 9;
   localparam int IW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic [PW-1:0] pc_next;
   logic          stall;
   logic [PW-1:0] pc;
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic          fetch_err;
   logic [7:0]    err_cnt;

   int total = 0;
   int bad   = 0;

   logic [PW+IW-1:0] sb[$];
   logic [PW+IW-1:0] e;

   instr_fetch_if #(.PC_W(PW), .INSTR_W(IW)) bus();

   instr_fetch #(
      .PC_W    (PW),
      .INSTR_W (IW),
      .RST_VEC (9'h1FF),
      .TIMEOUT (15)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_next     (pc_next),
      .stall       (stall),
      .imem        (bus),
      .pc          (pc),
      .instr       (instr),
      .instr_valid (instr_valid),
      .fetch_err   (fetch_err),
      .err_cnt     (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW+IW-1:0] pop_exp();
      if (sb.size() == 0)
         return '1;
      return sb.pop_front();
   endfunction

   // Called in a REQ cycle; returns in the EXEC cycle.
   task automatic serve(input logic [IW-1:0] d);
      cyc();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = d;
      cyc();
      bus.imem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst             = 1'b1;
      stall           = 1'b0;
      pc_next         = '0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      repeat (3) cyc();
      total++;
      if (pc !== 9'h1FF) begin
         bad++;
         $display("FAIL reset_pc got=%h want=1ff", pc);
      end
      total++;
      if (instr !== 12'h000) begin
         bad++;
         $display("FAIL reset_instr got=%h want=000", instr);
      end
      total++;
      if (instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctl got v=%b r=%b want 0 0",
                  instr_valid, bus.imem_req);
      end
      total++;
      if (bus.imem_addr !== 9'h1FF) begin
         bad++;
         $display("FAIL reset_addr got=%h want=1ff",
                  bus.imem_addr);
      end
      total++;
      if (fetch_err !== 1'b0 || err_cnt !== 8'd0) begin
         bad++;
         $display("FAIL reset_err got e=%b c=%0d want 0 0",
                  fetch_err, err_cnt);
      end
   endtask

   task automatic test_first_fetch();
      rst = 1'b0;
      cyc();
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h1FF) begin
         bad++;
         $display("FAIL first_req got r=%b a=%h want 1 1ff",
                  bus.imem_req, bus.imem_addr);
      end
      sb.push_back({9'h1FF, 12'hA05});
      cyc();
      total++;
      if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL first_wait got r=%b v=%b want 0 0",
                  bus.imem_req, instr_valid);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 12'hA05;
      cyc();
      bus.imem_rvalid = 1'b0;
      e = pop_exp();
      total++;
      if (instr_valid !== 1'b1 || pc !== e[PW+IW-1:IW] ||
          instr !== e[IW-1:0]) begin
         bad++;
         $display("FAIL first_exec got v=%b pc=%h i=%h want 1 %h %h",
                  instr_valid, pc, instr, e[PW+IW-1:IW], e[IW-1:0]);
      end
   endtask

   task automatic test_stall();
      stall   = 1'b1;
      pc_next = 9'h005;
      for (int i = 0; i < 4; i++) begin
         cyc();
         total++;
         if (instr_valid !== 1'b1 || pc !== 9'h1FF ||
             instr !== 12'hA05 || bus.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold%0d got v=%b pc=%h i=%h r=%b want 1 1ff a05 0",
                     i, instr_valid, pc, instr, bus.imem_req);
         end
      end
      stall = 1'b0;
      cyc();
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h005) begin
         bad++;
         $display("FAIL stall_next got r=%b a=%h want 1 005",
                  bus.imem_req, bus.imem_addr);
      end
      sb.push_back({9'h005, 12'h3C7});
      serve(12'h3C7);
      e = pop_exp();
      total++;
      if (instr_valid !== 1'b1 || pc !== e[PW+IW-1:IW] ||
          instr !== e[IW-1:0]) begin
         bad++;
         $display("FAIL stall_exec got v=%b pc=%h i=%h want 1 %h %h",
                  instr_valid, pc, instr, e[PW+IW-1:IW], e[IW-1:0]);
      end
   endtask

   task automatic test_timeout();
      int pulses = 0;
      int reqs   = 0;
      pc_next = 9'h0AA;
      cyc();
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h0AA) begin
         bad++;
         $display("FAIL to_req got r=%b a=%h want 1 0aa",
                  bus.imem_req, bus.imem_addr);
      end
      for (int i = 0; i < 15; i++) begin
         cyc();
         if (fetch_err === 1'b1) pulses++;
         if (bus.imem_req === 1'b1) reqs++;
      end
      total++;
      if (pulses != 0 || reqs != 0) begin
         bad++;
         $display("FAIL to_early got err=%0d req=%0d want 0 0",
                  pulses, reqs);
      end
      cyc();
      total++;
      if (fetch_err !== 1'b1 || err_cnt !== 8'd1) begin
         bad++;
         $display("FAIL to_pulse got e=%b c=%0d want 1 1",
                  fetch_err, err_cnt);
      end
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h0AA) begin
         bad++;
         $display("FAIL to_retry got r=%b a=%h want 1 0aa",
                  bus.imem_req, bus.imem_addr);
      end
      sb.push_back({9'h0AA, 12'h777});
      cyc();
      total++;
      if (fetch_err !== 1'b0) begin
         bad++;
         $display("FAIL to_onecycle got e=%b want 0", fetch_err);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 12'h777;
      cyc();
      bus.imem_rvalid = 1'b0;
      e = pop_exp();
      total++;
      if (instr_valid !== 1'b1 || pc !== e[PW+IW-1:IW] ||
          instr !== e[IW-1:0]) begin
         bad++;
         $display("FAIL to_exec got v=%b pc=%h i=%h want 1 %h %h",
                  instr_valid, pc, instr, e[PW+IW-1:IW], e[IW-1:0]);
      end
   endtask

   task automatic test_race();
      pc_next = 9'h155;
      cyc();
      sb.push_back({9'h155, 12'h9E1});
      repeat (15) cyc();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 12'h9E1;
      cyc();
      bus.imem_rvalid = 1'b0;
      e = pop_exp();
      total++;
      if (instr_valid !== 1'b1 || pc !== e[PW+IW-1:IW] ||
          instr !== e[IW-1:0]) begin
         bad++;
         $display("FAIL race_exec got v=%b pc=%h i=%h want 1 %h %h",
                  instr_valid, pc, instr, e[PW+IW-1:IW], e[IW-1:0]);
      end
      total++;
      if (fetch_err !== 1'b0 || err_cnt !== 8'd1) begin
         bad++;
         $display("FAIL race_err got e=%b c=%0d want 0 1",
                  fetch_err, err_cnt);
      end
   endtask

   task automatic test_wrap();
      pc_next = 9'h1FF;
      cyc();
      sb.push_back({9'h1FF, 12'h0F0});
      serve(12'h0F0);
      e = pop_exp();
      total++;
      if (pc !== e[PW+IW-1:IW] || instr !== e[IW-1:0]) begin
         bad++;
         $display("FAIL wrap_top got pc=%h i=%h want %h %h",
                  pc, instr, e[PW+IW-1:IW], e[IW-1:0]);
      end
      pc_next = 9'h000;
      cyc();
      total++;
      if (bus.imem_addr !== 9'h000 || fetch_err !== 1'b0) begin
         bad++;
         $display("FAIL wrap_req got a=%h e=%b want 000 0",
                  bus.imem_addr, fetch_err);
      end
      sb.push_back({9'h000, 12'h111});
      serve(12'h111);
      e = pop_exp();
      total++;
      if (pc !== e[PW+IW-1:IW] || instr !== e[IW-1:0]) begin
         bad++;
         $display("FAIL wrap_zero got pc=%h i=%h want %h %h",
                  pc, instr, e[PW+IW-1:IW], e[IW-1:0]);
      end
   endtask

   task automatic test_rst_wait();
      pc_next = 9'h123;
      cyc();
      cyc();
      rst             = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 12'hBAD;
      cyc();
      total++;
      if (pc !== 9'h1FF || instr !== 12'h000 ||
          instr_valid !== 1'b0 || err_cnt !== 8'd0) begin
         bad++;
         $display("FAIL rstw_reset got pc=%h i=%h v=%b c=%0d want 1ff 000 0 0",
                  pc, instr, instr_valid, err_cnt);
      end
      rst = 1'b0;
      cyc();
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h1FF ||
          instr !== 12'h000) begin
         bad++;
         $display("FAIL rstw_req got r=%b a=%h i=%h want 1 1ff 000",
                  bus.imem_req, bus.imem_addr, instr);
      end
      cyc();
      bus.imem_rvalid = 1'b0;
      cyc();
      total++;
      if (instr_valid !== 1'b0 || instr !== 12'h000) begin
         bad++;
         $display("FAIL rstw_stale got v=%b i=%h want 0 000",
                  instr_valid, instr);
      end
      sb.push_back({9'h1FF, 12'h5A5});
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 12'h5A5;
      cyc();
      bus.imem_rvalid = 1'b0;
      e = pop_exp();
      total++;
      if (instr_valid !== 1'b1 || pc !== e[PW+IW-1:IW] ||
          instr !== e[IW-1:0]) begin
         bad++;
         $display("FAIL rstw_exec got v=%b pc=%h i=%h want 1 %h %h",
                  instr_valid, pc, instr, e[PW+IW-1:IW], e[IW-1:0]);
      end
   endtask

   task automatic test_saturate();
      int pulses = 0;
      int model  = 0;
      int guard  = 0;
      logic [7:0] m8;
      pc_next = 9'h040;
      cyc();
      while (pulses < 256 && guard < 256 * 16 + 64) begin
         cyc();
         guard++;
         if (fetch_err === 1'b1) begin
            pulses++;
            model = (model == 255) ? 255 : model + 1;
            m8 = model[7:0];
            if (pulses == 1 || pulses >= 255) begin
               total++;
               if (err_cnt !== m8) begin
                  bad++;
                  $display("FAIL sat_cnt%0d got=%0d want=%0d",
                           pulses, err_cnt, m8);
               end
            end
         end
      end
      total++;
      if (pulses != 256) begin
         bad++;
         $display("FAIL sat_pulses got=%0d want=256", pulses);
      end
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h040) begin
         bad++;
         $display("FAIL sat_retry got r=%b a=%h want 1 040",
                  bus.imem_req, bus.imem_addr);
      end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_stall();
      test_timeout();
      test_race();
      test_wrap();
      test_rst_wait();
      test_saturate();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_left got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL declare parameter PC_W, default 9, meaning program-counter width.
REQ-002 The module SHALL declare parameter INSTR_W, default 12, meaning instruction width.
REQ-003 The module SHALL declare parameter RST_VEC, default 9'h1FF, meaning the reset program address.
REQ-004 The module SHALL declare parameter TIMEOUT, default 15, meaning the number of WAIT cycles before a fetch is re-issued.
REQ-005 The module SHALL have these ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high.
- pc_next  in  PC_W  next address from the sequencer.
- stall  in  1  execute stage holds the current instruction.
- imem_req  out  1  single-cycle fetch request strobe.
- imem_addr  out  PC_W  fetch address.
- imem_rvalid  in  1  fetch response valid.
- imem_rdata  in  INSTR_W  fetch response data.
- pc  out  PC_W  address of the current instruction.
- instr  out  INSTR_W  current instruction register.
- instr_valid  out  1  instr/pc are executable this cycle.
- fetch_err  out  1  one-cycle pulse on a fetch timeout.
- err_cnt  out  8  saturating count of timeouts.

Function
REQ-006 The FSM SHALL have four states: RESET, REQ, WAIT and EXEC; only one fetch SHALL ever be outstanding.
REQ-007 In RESET, the FSM SHALL go to REQ on the next clock while rst=0.
REQ-008 In REQ, imem_req=1 and imem_addr=pc for exactly one cycle, then the FSM SHALL go to WAIT with the timeout counter cleared.
REQ-009 In WAIT with imem_rvalid=1, the FSM SHALL capture imem_rdata into instr and go to EXEC.
REQ-010 In WAIT with imem_rvalid=0, the timeout counter SHALL increment; on reaching TIMEOUT, fetch_err SHALL pulse for one cycle, err_cnt SHALL increment (saturating at 255), and the FSM SHALL return to REQ with pc unchanged.
REQ-011 If imem_rvalid=1 in the same cycle the counter reaches TIMEOUT, the response SHALL win: no fetch_err, and the FSM SHALL go to EXEC.
REQ-012 imem_rvalid SHALL be ignored in RESET, REQ and EXEC; stale responses are discarded.
REQ-013 instr_valid SHALL be 1 only in EXEC.
REQ-014 In EXEC with stall=0, pc SHALL load pc_next and the FSM SHALL go to REQ.
REQ-015 In EXEC with stall=1, the state, pc and instr SHALL all hold.
REQ-016 pc SHALL be registered, and pc_next SHALL be sampled only in EXEC with stall=0.
REQ-017 pc arithmetic SHALL be PC_W-bit modulo: a pc_next of 9'h000 after 9'h1FF is legal and is not flagged.
REQ-018 instr SHALL hold its last captured value outside EXEC.
REQ-019 Zero-latency throughput SHALL be one instruction per 3 cycles when the memory latency is 1 (REQ, WAIT, EXEC).

Reset
REQ-020 While rst=1: state=RESET, pc=RST_VEC, instr=12'h000 (NOP), instr_valid=0, imem_req=0, imem_addr=RST_VEC, fetch_err=0, err_cnt=0, and the timeout counter=0.
REQ-021 rst asserted in any state, including WAIT with a fetch outstanding, SHALL abandon the fetch; the first request after reset SHALL address RST_VEC.
REQ-022 rst SHALL take priority over stall and imem_rvalid.

Structure
REQ-023 PC_W, INSTR_W, RST_VEC, the NOP encoding and the FSM state encoding SHALL live in the shared package cpu_pkg.
REQ-024 The timeout counter with its saturating error count SHALL be one sub-module, fetch_timeout; all other logic SHALL stay in instr_fetch.

Verification
REQ-025 Reset release, with memory latency 1 returning 12'hA05 for address 1FF: imem_req SHALL occur at cycle 1 with addr 1FF, and instr_valid=1 with instr=A05, pc=1FF at cycle 3.
REQ-026 EXEC with pc_next=9'h005 and stall high for 4 cycles: instr and pc SHALL hold for all 4 cycles, and the next imem_addr SHALL be 005 on the cycle after stall falls.
REQ-027 No response for 15 WAIT cycles: fetch_err SHALL pulse once, err_cnt SHALL equal 1, and imem_req SHALL re-issue to the same address; a response on retry SHALL give a normal EXEC.
REQ-028 imem_rvalid arriving on the exact cycle the counter reaches TIMEOUT: instr SHALL be captured, with no fetch_err and err_cnt unchanged.
REQ-029 rst pulsed during WAIT, followed by a stale imem_rvalid in RESET or REQ: the stale data SHALL be ignored, and the next fetch SHALL be addressed to 1FF.
REQ-030 256 consecutive timeouts: err_cnt SHALL saturate at 255 and SHALL not wrap.
